// File: rtl/wrr_lock_arbiter_if.sv
// Request/grant bundle between requesters and the weighted
// round-robin lock arbiter.
interface wrr_lock_arbiter_if #(
  parameter int NUM_REQ  = 16,
  parameter int WEIGHT_W = 2
);
  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]          req;
  logic [NUM_REQ*WEIGHT_W-1:0] weight;
  logic                        done;
  logic [NUM_REQ-1:0]          grant;
  logic [IDX_W-1:0]            grant_id;
  logic                        grant_valid;

  modport master (
    output req, weight, done,
    input  grant, grant_id, grant_valid
  );

  modport slave (
    input  req, weight, done,
    output grant, grant_id, grant_valid
  );
endinterface

// File: rtl/wrr_lock_arbiter.sv
// Weighted round-robin arbiter with locked grants held until done;
// each owner keeps the resource for up to weight+1 transactions.
module wrr_lock_arbiter #(
  parameter int NUM_REQ  = 16,
  parameter int WEIGHT_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  wrr_lock_arbiter_if.slave   bus
);
  localparam int IDX_W = $clog2(NUM_REQ);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t              state_q, state_d;
  logic [IDX_W-1:0]    owner_q, owner_d;
  logic [IDX_W-1:0]    ptr_q, ptr_d;
  logic [WEIGHT_W-1:0] credit_q, credit_d;

  logic [IDX_W-1:0]    base;
  logic [IDX_W-1:0]    sel_idx;
  logic [IDX_W-1:0]    cand;
  logic                sel_found;
  logic [WEIGHT_W-1:0] sel_weight;
  int                  t;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      ptr_q    <= IDX_W'(NUM_REQ - 1);
      credit_q <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      ptr_q    <= ptr_d;
      credit_q <= credit_d;
    end
  end

  // Scan starts after the current owner when busy so it is eligible last
  always_comb begin
    base      = (state_q == BUSY) ? owner_q : ptr_q;
    sel_found = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    t         = 0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      t    = (int'(base) + k) % NUM_REQ;
      cand = IDX_W'(t);
      if (!sel_found && bus.req[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
    sel_weight = bus.weight[sel_idx*WEIGHT_W +: WEIGHT_W];
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    ptr_d    = ptr_q;
    credit_d = credit_q;
    unique case (state_q)
      IDLE: begin
        if (|bus.req) begin
          state_d  = BUSY;
          owner_d  = sel_idx;
          credit_d = sel_weight;
        end
      end
      BUSY: begin
        if (bus.done) begin
          if (bus.req[owner_q] && credit_q != '0) begin
            credit_d = credit_q - WEIGHT_W'(1);
          end else begin
            ptr_d = owner_q;
            if (sel_found) begin
              owner_d  = sel_idx;
              credit_d = sel_weight;
            end else begin
              state_d  = IDLE;
              credit_d = '0;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.grant       = '0;
    bus.grant_valid = (state_q == BUSY);
    bus.grant_id    = owner_q;
    if (state_q == BUSY) bus.grant[owner_q] = 1'b1;
  end
endmodule
